row_loader: RTL
===============

ROW_LOADER -- requirements
Module: row_loader

Interface
REQ-001 SHALL have parameter BLOCK_NUM, default 40, number of processing blocks per row.
REQ-002 SHALL have parameter NUM_WIDTH, default 6, block index width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 30, pixels per block.
REQ-004 SHALL have parameter ADDR_WIDTH, default 5, block memory address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 128, pixel word width (4 peaks x (18b signal + 14b distance)).
REQ-006 SHALL have parameter TIMEOUT, default 4096, watchdog limit in cycles.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH), the pixel stream handshake.
REQ-010 SHALL have port in_last, input, 1, upstream end-of-row marker.
REQ-011 SHALL have ports wr_en (output, 1), wr_block (output, NUM_WIDTH), wr_addr (output, ADDR_WIDTH) and wr_data (output, DATA_WIDTH), the block memory write port.
REQ-012 SHALL have ports core_start (output, 1) and core_end (input, 1), the core handshake.
REQ-013 SHALL have outputs busy (1), err_len (1), timeout (1) and row_cnt (16).

Function
REQ-014 SHALL transfer a beat only in cycles where in_valid and in_ready are both 1.
REQ-015 SHALL use states LOAD, DRAIN, KICK and WAIT, with in_ready=1 only in LOAD and busy=1 in every state except LOAD.
REQ-016 SHALL map each accepted beat to the next (block, addr) position, starting at (0,0); addr increments to BLOCK_SIZE-1, then wraps to 0 while block increments.
REQ-017 SHALL drive a beat accepted in cycle t as wr_en=1 with its block, addr and data in cycle t+1 (registered, one-cycle latency), and wr_en=0 otherwise.
REQ-018 SHALL fix row length by count (BLOCK_NUM*BLOCK_SIZE beats, 1200 by default) and never by in_last.
REQ-019 SHALL, on acceptance of beat (BLOCK_NUM-1, BLOCK_SIZE-1) in cycle t, enter DRAIN at t+1 and KICK at t+2, and return the position counters to (0,0).
REQ-020 SHALL assert core_start for exactly one cycle, while in KICK, then enter WAIT.
REQ-021 SHALL leave WAIT on a cycle with core_end=1, incrementing row_cnt (wrapping at 2^16) and entering LOAD in the next cycle.
REQ-022 SHALL ignore core_end in the LOAD, DRAIN and KICK states.
REQ-023 SHALL pulse err_len for one cycle, together with that beat's wr_en, when in_last is 1 on a non-final beat or 0 on the final beat; the data is still written and the row proceeds.
REQ-024 SHALL, when a beat completes a row, take no further beat until WAIT exits; in_ready drops in the cycle after the final acceptance.

Reset
REQ-025 SHALL, while rst_n=0, force: state LOAD, counters (0,0), row_cnt=0, and wr_en, core_start, err_len and timeout all 0.
REQ-026 SHALL, if reset is asserted mid-row or in WAIT, discard the partial row and issue no core_start; after release, the first accepted beat goes to (0,0).
REQ-027 SHALL leave in_ready=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, when ROW_LOADER_TIMEOUT_EN is defined, count the cycles spent in WAIT.
REQ-029 SHALL, when ROW_LOADER_TIMEOUT_EN is defined and TIMEOUT cycles pass in WAIT without core_end, pulse timeout for one cycle, enter LOAD, and leave row_cnt unchanged.
REQ-030 SHALL, when ROW_LOADER_TIMEOUT_EN is undefined, contain no watchdog counter, tie timeout to 0, and wait for core_end indefinitely.

Verification
REQ-031 SHALL cover: after reset, stream 1200 beats with data equal to the beat index and in_last only on beat 1199 -> 1200 writes in the order (0,0)..(39,29), beat 30 at (1,0), core_start in the 2nd cycle after the last acceptance, err_len never asserted.
REQ-032 SHALL cover: core_end 10 cycles after core_start -> row_cnt=1 and in_ready=1 in the next cycle; a second row is then written starting at (0,0).
REQ-033 SHALL cover: in_last on beat 599 -> one err_len pulse with the write to (19,29); loading continues to 1200 beats and core_start is still issued.
REQ-034 SHALL cover: in_valid toggled randomly with 50% gaps -> write order and contents are identical to REQ-031.
REQ-035 SHALL cover: rst_n pulsed low after 700 beats -> no core_start, row_cnt=0, and the next accepted beat is written to (0,0).
REQ-036 SHALL cover: with ROW_LOADER_TIMEOUT_EN defined, TIMEOUT=16 and core_end withheld -> timeout pulses 16 cycles after WAIT is entered, then LOAD is entered with row_cnt unchanged; with the macro undefined -> WAIT persists.

Source files
------------

// File: rtl/row_loader.sv
// row_loader: streams one row of pixels into block memory, then starts the core and waits for it to finish.
// Defining ROW_LOADER_TIMEOUT_EN adds a watchdog on the WAIT state.
module row_loader #(
  parameter int BLOCK_NUM  = 40,
  parameter int NUM_WIDTH  = 6,
  parameter int BLOCK_SIZE = 30,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [NUM_WIDTH-1:0]  wr_block,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  core_start,
  input  logic                  core_end,
  output logic                  busy,
  output logic                  err_len,
  output logic                  timeout,
  output logic [15:0]           row_cnt
);
  localparam logic [1:0] LOAD = 2'd0, DRAIN = 2'd1, KICK = 2'd2, WAIT = 2'd3;
  logic [1:0] state, state_nxt;
  logic [NUM_WIDTH-1:0] blk;
  logic [ADDR_WIDTH-1:0] addr;
  logic acc, last_addr, last_beat, wd_hit;
  assign in_ready   = state == LOAD;
  assign busy       = state != LOAD;
  assign core_start = state == KICK;
  assign acc        = in_valid && in_ready;
  assign last_addr  = addr == ADDR_WIDTH'(BLOCK_SIZE - 1);
  assign last_beat  = last_addr && blk == NUM_WIDTH'(BLOCK_NUM - 1);
  always_comb
    state_nxt = state == LOAD  ? (acc && last_beat ? DRAIN : LOAD) :
                state == DRAIN ? KICK :
                state == KICK  ? WAIT :
                core_end || wd_hit ? LOAD : WAIT;
  // Row length is fixed by count; in_last only feeds the length-error flag.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= LOAD;
      blk      <= '0;
      addr     <= '0;
      row_cnt  <= '0;
      wr_en    <= 1'b0;
      err_len  <= 1'b0;
      wr_block <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state   <= state_nxt;
      wr_en   <= acc;
      err_len <= acc && (in_last != last_beat);
      if (acc) begin
        wr_block <= blk;
        wr_addr  <= addr;
        wr_data  <= in_data;
        addr     <= last_addr ? '0 : addr + 1'b1;
        blk      <= last_beat ? '0 : last_addr ? blk + 1'b1 : blk;
      end
      if (state == WAIT && core_end)
        row_cnt <= row_cnt + 1'b1;
    end
`ifdef ROW_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] wdog;
  assign wd_hit = state == WAIT && !core_end && wdog == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      wdog    <= state == WAIT && !core_end && !wd_hit ? wdog + 1'b1 : '0;
      timeout <= wd_hit;
    end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule
